// File: rtl/multdiv_unit.sv
// multdiv_unit
//   Multi-cycle signed 32x32 multiply / 32/32 divide beside the execute-stage
//   ALU. A one-cycle strobe starts an operation; the result is available
//   33 cycles after the start edge, flagged by a one-cycle data_resultRDY.
//
// Ports
//   clock          : rising-edge clock
//   reset          : asynchronous active-low reset, clears state and outputs
//   data_operandA  : multiplicand / dividend (two's complement), start edge only
//   data_operandB  : multiplier / divisor (two's complement), start edge only
//   ctrl_MULT      : start strobe, multiply (wins over ctrl_DIV)
//   ctrl_DIV       : start strobe, divide
//   data_result    : low 32 product bits or truncated quotient (registered)
//   data_exception : multiply overflow, divide overflow or divide-by-zero
//   data_resultRDY : one-cycle pulse, result/exception valid
//   busy           : high while an operation is in flight (MUL, DIV, FIX)
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;       // MUL: product accumulator; DIV: quotient in [31:0]
    logic [31:0] rem;       // DIV remainder, always < divisor <= 2^31
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sign_res;
    logic        op_div;

    logic        start;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;

    logic [63:0] prod_signed;
    logic [31:0] quot_signed;
    logic        div_zero;
    logic        mul_exc;
    logic        div_exc;
    logic [31:0] fix_result;
    logic        fix_exc;

    assign start = ctrl_MULT | ctrl_DIV;

    // |0x80000000| wraps to 0x80000000, which is the correct unsigned 2^31.
    assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Shift-add: the multiplier bit for this iteration adds the multiplicand
    // into the upper half, then the whole accumulator shifts right by one.
    // After 32 iterations bit i's contribution has landed at weight 2^i.
    assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (mag_b[cnt[4:0]] ? mag_a : 32'd0)};

    // Restoring division: the 33-bit partial remainder is the held remainder
    // with the next dividend bit (MSB first) shifted in.
    assign div_shift = {rem, mag_a[5'd31 - cnt[4:0]]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ge    = ~div_diff[32];

    assign prod_signed = sign_res ? (~acc + 64'd1) : acc;
    assign quot_signed = sign_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign div_zero    = (mag_b == 32'd0);
    assign mul_exc     = ~(&prod_signed[63:31]) & (|prod_signed[63:31]);
    // The only magnitude quotient reaching 2^31 with a positive sign is
    // 0x80000000 / -1; its raw bits already equal 0x80000000.
    assign div_exc     = div_zero | (~sign_res & acc[31]);

    always_comb begin
        fix_result = prod_signed[31:0];
        fix_exc    = mul_exc;
        if (op_div) begin
            fix_result = div_zero ? 32'd0 : quot_signed;
            fix_exc    = div_exc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            acc            <= '0;
            rem            <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            sign_res       <= 1'b0;
            op_div         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (start) begin
            // A start in any state aborts whatever was running.
            mag_a          <= abs_a;
            mag_b          <= abs_b;
            sign_res       <= data_operandA[31] ^ data_operandB[31];
            op_div         <= ~ctrl_MULT;
            acc            <= '0;
            rem            <= '0;
            cnt            <= '0;
            state          <= ctrl_MULT ? S_MUL : S_DIV;
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    acc <= {mul_sum, acc[31:1]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    rem        <= div_ge ? div_diff[31:0] : div_shift[31:0];
                    acc[31:0]  <= {acc[30:0], div_ge};
                    cnt        <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    data_result    <= fix_result;
                    data_exception <= fix_exc;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    data_resultRDY <= 1'b0;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multi-cycle signed 32-bit multiply/divide unit in the CPU execute stage, beside the combinational ALU. Decode pulses a start strobe with the same operands it presents to the ALU. While the unit runs, the pipeline stalls on `busy`. On `data_resultRDY`, execute selects this block's `data_result` in place of the ALU result into the X/M latch. `data_exception` drives the `$rstatus` exception write, as ALU `overflow` does.

## Interface
Parameters:
- none (datapath fixed at 32 bits, iteration count fixed at 32)

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; low forces IDLE and clears all outputs
- `data_operandA`  in  32  multiplicand / dividend, two's complement; sampled only on a start edge
- `data_operandB`  in  32  multiplier / divisor, two's complement; sampled only on a start edge
- `ctrl_MULT`  in  1  one-cycle start strobe for multiply
- `ctrl_DIV`  in  1  one-cycle start strobe for divide
- `data_result`  out  32  low 32 bits of the product, or the quotient; registered
- `data_exception`  out  1  overflow / divide-by-zero flag for the current result; registered
- `data_resultRDY`  out  1  one-cycle pulse: result and exception are valid
- `busy`  out  1  high while an operation is in flight (MUL, DIV or FIX state)

## Operation
- States and transitions:
  - IDLE: start seen → MUL or DIV.
  - MUL / DIV: 32 iterations → FIX.
  - FIX: → DONE.
  - DONE: one cycle → IDLE.
- 6-bit iteration counter, cleared on start and incremented per iteration edge.
- Start edge (MULT or DIV high at a rising edge, any state):
  - latch |A| and |B| magnitudes plus the result sign (A[31]^B[31]);
  - latch A[31] and the operation type;
  - clear the accumulator and counter;
  - enter MUL or DIV.
- Start priority: if `ctrl_MULT` and `ctrl_DIV` are high together, multiply wins.
- Start while busy: abort the current operation with no RDY, then restart with the new operands. The restart edge behaves as a normal start.
- MUL: unsigned shift-add over magnitudes, one multiplier bit per cycle, into a 64-bit accumulator.
- DIV: restoring division over magnitudes, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX (one cycle):
  - Negate the magnitude result if the sign bit is set (magnitude-zero results stay 0).
  - Write `data_result` and `data_exception`.
- Multiply exception: the signed 64-bit product is outside [-2^31, 2^31-1], i.e. bits [63:31] are not all equal. `data_result` = product[31:0] regardless.
- Divide semantics: quotient truncated toward zero; the remainder is discarded.
- Divide by zero (B == 0):
  - `data_result` = 0, `data_exception` = 1;
  - full latency still applies; no early exit.
- Divide overflow (A == 0x80000000, B == 0xFFFFFFFF): `data_result` = 0x80000000, `data_exception` = 1.
- Arithmetic width rules:
  - |0x80000000| is treated as unsigned 2^31, which fits the 32-bit magnitude register.
  - All internal adds are unsigned, at 33 bits (DIV) or 64 bits (MUL).
- Output holding: `data_result` and `data_exception` hold their value until the FIX of the next completed operation. They are not cleared on start.

## Timing
- Reset (`reset` low, asynchronous) drives all of the following:
  - state = IDLE, counter = 0;
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
- Deassertion of `reset` is synchronised externally; the first valid start is one edge after release.
- Reset mid-operation: immediate return to IDLE, no RDY pulse, outputs zeroed.
- Latency, with edge E0 as the start edge:
  - iteration edges are E1..E32;
  - FIX completes at E33;
  - `data_resultRDY` is high from E33 to E34;
  - 33 cycles start-to-RDY, identical for MUL and DIV.
- `busy` timing:
  - rises after E0;
  - stays high through the cycle ending at E33;
  - is low in the cycle RDY is high.
- Back-to-back: a start presented in the RDY cycle is accepted at E34. That cycle's RDY pulse still completes.
- Operands and strobes are ignored on all non-start edges. Operand changes mid-operation have no effect.
- Strobes are assumed one cycle wide. A strobe held high restarts the operation on every edge and never completes; this is required behaviour.

## Test plan
- MULT, A=7, B=-6 (0xFFFFFFFA) → RDY exactly 33 cycles after the start edge; `data_result`=0xFFFFFFD6; exception=0; `busy` high for 33 cycles.
- MULT, A=0x00010000, B=0x00010000 → `data_result`=0x00000000, exception=1. Follow with MULT, A=0x80000000, B=1 → 0x80000000, exception=0.
- DIV, A=-7, B=2 → `data_result`=0xFFFFFFFD (-3), exception=0. Follow with DIV, A=100, B=7 → 14.
- DIV, A=5, B=0 → `data_result`=0, exception=1, RDY at 33 cycles. Follow with DIV, A=0x80000000, B=0xFFFFFFFF → 0x80000000, exception=1.
- Restart: MULT 3×4 started, then at cycle 10 DIV 20/5 → no RDY for the multiply; RDY 33 cycles after the DIV edge with result 4. Simultaneous MULT+DIV with A=6, B=3 → 18.
- Reset: drive `reset` low mid-DIV at cycle 15 → `busy`, RDY, `data_result` and exception go to 0 asynchronously, before the next edge. After release, a new MULT 2×3 → 6 at 33 cycles.
